// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - shared decode codes, opcodes and decoded-entry record
package decode_stage_pkg;

  // ALU / branch operation codes carried in aluOperation
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_LUI  = 5'd10;
  localparam logic [4:0] ALU_MUL  = 5'd11;
  localparam logic [4:0] ALU_MULH = 5'd12;
  localparam logic [4:0] ALU_DIV  = 5'd13;
  localparam logic [4:0] ALU_REM  = 5'd14;
  localparam logic [4:0] ALU_BEQ  = 5'd16;
  localparam logic [4:0] ALU_BNE  = 5'd17;
  localparam logic [4:0] ALU_BLT  = 5'd18;
  localparam logic [4:0] ALU_BGE  = 5'd19;
  localparam logic [4:0] ALU_BLTU = 5'd20;
  localparam logic [4:0] ALU_BGEU = 5'd21;
  localparam logic [4:0] ALU_JAL  = 5'd22;
  localparam logic [4:0] ALU_JALR = 5'd23;

  // Immediate formats carried in immediateSelect
  localparam logic [2:0] IMM_R = 3'd0;
  localparam logic [2:0] IMM_I = 3'd1;
  localparam logic [2:0] IMM_S = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;
  localparam logic [2:0] IMM_J = 3'd5;

  // RV32 major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULD = 7'b0000001;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  // One decoded entry minus the XLEN-wide immediate, which is stored alongside
  typedef struct packed {
    logic [4:0] alu_op;
    logic [2:0] imm_sel;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       illegal;
  } dec_entry_t;

endpackage

// File: rtl/rv_decode_comb.sv
// rtl/rv_decode_comb.sv - combinational RV32I(+M) instruction decoder
module rv_decode_comb
  import decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [XLEN-1:0] inst_i,
  output dec_entry_t      entry_o,
  output logic [XLEN-1:0] imm_o,
  output logic            halt_o
);

  logic [31:0] w;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        legal;
  logic [4:0]  alu;
  logic [2:0]  sel;
  logic [31:0] imm32;

  assign w   = inst_i[31:0];
  assign opc = w[6:0];
  assign f3  = w[14:12];
  assign f7  = w[31:25];

  // Classify the opcode/funct fields; unsupported encodings collapse to all-zero fields
  always_comb begin
    legal = 1'b0;
    alu   = ALU_ADD;
    sel   = IMM_R;
    case (opc)
      OPC_LUI:   begin legal = 1'b1; alu = ALU_LUI; sel = IMM_U; end
      OPC_AUIPC: begin legal = 1'b1; sel = IMM_U; end
      OPC_JAL:   begin legal = 1'b1; alu = ALU_JAL; sel = IMM_J; end
      OPC_JALR:  begin legal = (f3 == 3'b000); alu = ALU_JALR; sel = IMM_I; end
      OPC_BRANCH: begin
        legal = 1'b1;
        sel   = IMM_B;
        case (f3)
          3'b000:  alu = ALU_BEQ;
          3'b001:  alu = ALU_BNE;
          3'b100:  alu = ALU_BLT;
          3'b101:  alu = ALU_BGE;
          3'b110:  alu = ALU_BLTU;
          3'b111:  alu = ALU_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD:  begin legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}; sel = IMM_I; end
      OPC_STORE: begin legal = f3 inside {3'b000, 3'b001, 3'b010}; sel = IMM_S; end
      OPC_OPIMM: begin
        legal = 1'b1;
        sel   = IMM_I;
        case (f3)
          3'b000: alu = ALU_ADD;
          3'b001: begin alu = ALU_SLL; legal = (f7 == F7_BASE); end
          3'b010: alu = ALU_SLT;
          3'b011: alu = ALU_SLTU;
          3'b100: alu = ALU_XOR;
          3'b101: begin
            alu   = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            legal = (f7 == F7_BASE) || (f7 == F7_ALT);
          end
          3'b110: alu = ALU_OR;
          default: alu = ALU_AND;
        endcase
      end
      OPC_OP: begin
        sel = IMM_R;
        if (f7 == F7_BASE) begin
          legal = 1'b1;
          case (f3)
            3'b000: alu = ALU_ADD;
            3'b001: alu = ALU_SLL;
            3'b010: alu = ALU_SLT;
            3'b011: alu = ALU_SLTU;
            3'b100: alu = ALU_XOR;
            3'b101: alu = ALU_SRL;
            3'b110: alu = ALU_OR;
            default: alu = ALU_AND;
          endcase
        end else if (f7 == F7_ALT) begin
          legal = (f3 == 3'b000) || (f3 == 3'b101);
          alu   = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
        end else if (f7 == F7_MULD) begin
          // Signedness variants share one code: MULH*, DIV/DIVU, REM/REMU
          legal = ENABLE_M;
          case (f3[2:1])
            2'b00:   alu = f3[0] ? ALU_MULH : ALU_MUL;
            2'b01:   alu = ALU_MULH;
            2'b10:   alu = ALU_DIV;
            default: alu = ALU_REM;
          endcase
        end
      end
      OPC_SYSTEM: begin
        legal = (w == INST_ECALL) || (w == INST_EBREAK);
        sel   = IMM_I;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      alu = ALU_ADD;
      sel = IMM_R;
    end
  end

  // Assemble the immediate for the selected format; R-type and illegal give zero
  always_comb begin
    imm32 = 32'd0;
    case (sel)
      IMM_I: imm32 = {{20{w[31]}}, w[31:20]};
      IMM_S: imm32 = {{20{w[31]}}, w[31:25], w[11:7]};
      IMM_B: imm32 = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      IMM_U: imm32 = {w[31:12], 12'd0};
      IMM_J: imm32 = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));

  assign entry_o.alu_op  = alu;
  assign entry_o.imm_sel = sel;
  assign entry_o.rs1     = w[19:15];
  assign entry_o.rs2     = w[24:20];
  assign entry_o.rd      = w[11:7];
  assign entry_o.illegal = !legal;

  assign halt_o = (w == INST_ECALL) || (w == INST_EBREAK);

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - decode stage with FIFO output buffer and ECALL/EBREAK halt
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter bit ENABLE_M = 1'b0,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] inst,
  input  logic            flush,
  input  logic            resume,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      aluOperation,
  output logic [2:0]      immediateSelect,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            illegal,
  output logic            stop
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]   DEPTH_C = DEPTH[PW:0];
  localparam logic [PW:0]   CNT_ONE = 1;
  localparam logic [PW-1:0] PTR_ONE = 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          halt_q, halt_d;

  dec_entry_t      entry_mem [DEPTH];
  logic [XLEN-1:0] imm_mem   [DEPTH];

  dec_entry_t      dec_entry;
  logic [XLEN-1:0] dec_imm;
  logic            dec_halt;
  logic            full;
  logic            accept;
  logic            pop;
  dec_entry_t      head;

  rv_decode_comb #(
    .XLEN     (XLEN),
    .ENABLE_M (ENABLE_M)
  ) u_dec (
    .inst_i  (inst),
    .entry_o (dec_entry),
    .imm_o   (dec_imm),
    .halt_o  (dec_halt)
  );

  assign full      = (count_q == DEPTH_C);
  assign out_valid = (count_q != '0);
  // No same-cycle pass-through: a pop never frees a slot for this cycle's input
  assign in_ready  = rst_n & !full & !halt_q & !flush;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Buffer pointer/count and halt next-state; flush clears the buffer but not halt
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    halt_d   = halt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)    rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (accept && !pop)      count_d = count_q + CNT_ONE;
      else if (!accept && pop) count_d = count_q - CNT_ONE;
    end
    if (resume)             halt_d = 1'b0;
    if (accept && dec_halt) halt_d = 1'b1;
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      halt_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      halt_q   <= halt_d;
    end
  end

  // Entry storage; contents only matter while counted, so no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      entry_mem[wr_ptr_q] <= dec_entry;
      imm_mem[wr_ptr_q]   <= dec_imm;
    end
  end

  assign head            = entry_mem[rd_ptr_q];
  assign aluOperation    = out_valid ? head.alu_op  : '0;
  assign immediateSelect = out_valid ? head.imm_sel : '0;
  assign imm             = out_valid ? imm_mem[rd_ptr_q] : '0;
  assign rs1             = out_valid ? head.rs1     : '0;
  assign rs2             = out_valid ? head.rs2     : '0;
  assign rd              = out_valid ? head.rd      : '0;
  assign illegal         = out_valid ? head.illegal : 1'b0;
  assign stop            = halt_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n, in_valid, flush, resume, out_ready;
  logic [31:0] inst;

  logic o_rdy, o_vld, o_ill, o_stop;
  logic [4:0] o_alu, o_rs1, o_rs2, o_rd;
  logic [2:0] o_sel;
  logic [31:0] o_imm;
  logic m_rdy, m_vld, m_ill, m_stop;
  logic [4:0] m_alu, m_rs1, m_rs2, m_rd;
  logic [2:0] m_sel;
  logic [31:0] m_imm;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  decode_stage #(.DEPTH(DEPTH), .ENABLE_M(1'b0), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_rdy), .inst(inst),
    .flush(flush), .resume(resume), .out_valid(o_vld), .out_ready(out_ready),
    .aluOperation(o_alu), .immediateSelect(o_sel), .imm(o_imm),
    .rs1(o_rs1), .rs2(o_rs2), .rd(o_rd), .illegal(o_ill), .stop(o_stop)
  );

  decode_stage #(.DEPTH(DEPTH), .ENABLE_M(1'b1), .XLEN(32)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_rdy), .inst(inst),
    .flush(flush), .resume(resume), .out_valid(m_vld), .out_ready(out_ready),
    .aluOperation(m_alu), .immediateSelect(m_sel), .imm(m_imm),
    .rs1(m_rs1), .rs2(m_rs2), .rd(m_rd), .illegal(m_ill), .stop(m_stop)
  );

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  alu;
    logic [2:0]  sel;
    logic [31:0] imm;
    logic        ill;
    logic [4:0]  alu_m;
    logic        ill_m;
  } vec_t;

  typedef struct {
    logic [4:0]  alu;
    logic [2:0]  sel;
    logic [31:0] imm;
    logic        ill;
  } ref_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_halt(logic [31:0] w);
    return (w == 32'h0000_0073) || (w == 32'h0010_0073);
  endfunction

  // Reference decoder from the ISA tables, using lookup arrays and integer arithmetic
  function automatic ref_t ref_dec(logic [31:0] w, bit en_m);
    int br[8] = '{16, 17, -1, -1, 18, 19, 20, 21};
    int ar[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int mm[8] = '{11, 12, 12, 12, 13, 13, 14, 14};
    int op = -1;
    int sel = 0;
    int iv = 0;
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    ref_t r;
    case (w[6:0])
      7'h37: begin op = 10; sel = 4; end
      7'h17: begin op = 0; sel = 4; end
      7'h6F: begin op = 22; sel = 5; end
      7'h67: if (f3 == 0) begin op = 23; sel = 1; end
      7'h63: begin op = br[f3]; sel = 3; end
      7'h03: if (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) begin op = 0; sel = 1; end
      7'h23: if (f3 <= 2) begin op = 0; sel = 2; end
      7'h13: begin
        sel = 1;
        if (f3 == 1) op = (f7 == 0) ? 2 : -1;
        else if (f3 == 5) op = (f7 == 0) ? 6 : (f7 == 32) ? 7 : -1;
        else op = ar[f3];
      end
      7'h33: begin
        sel = 0;
        if (f7 == 0) op = ar[f3];
        else if (f7 == 32) op = (f3 == 0) ? 1 : (f3 == 5) ? 7 : -1;
        else if (f7 == 1) op = en_m ? mm[f3] : -1;
      end
      7'h73: if (is_halt(w)) begin op = 0; sel = 1; end
      default: op = -1;
    endcase
    if (op < 0) begin
      r.alu = 0; r.sel = 0; r.imm = 0; r.ill = 1'b1;
      return r;
    end
    case (sel)
      1: iv = int'($signed(w[31:20]));
      2: iv = int'($signed({w[31:25], w[11:7]}));
      3: iv = 2 * int'($signed({w[31], w[7], w[30:25], w[11:8]}));
      4: iv = int'(w[31:12]) * 4096;
      5: iv = 2 * int'($signed({w[31], w[19:12], w[20], w[30:21]}));
      default: iv = 0;
    endcase
    r.alu = 5'(op);
    r.sel = 3'(sel);
    r.imm = 32'(iv);
    r.ill = 1'b0;
    return r;
  endfunction

  vec_t vt[14];
  logic [31:0] mq[$];
  bit          mhalt;
  logic [6:0]  opcs[10];

  initial begin
    vt[0]  = '{32'h402081B3, 1,  0, 32'h0,        0, 1,  0};
    vt[1]  = '{32'h040000EF, 22, 5, 32'd64,       0, 22, 0};
    vt[2]  = '{32'h0420C063, 18, 3, 32'd64,       0, 18, 0};
    vt[3]  = '{32'h02208133, 0,  0, 32'h0,        1, 11, 0};
    vt[4]  = '{32'hFFF00093, 0,  1, 32'hFFFFFFFF, 0, 0,  0};
    vt[5]  = '{32'h123452B7, 10, 4, 32'h12345000, 0, 10, 0};
    vt[6]  = '{32'h0020A423, 0,  2, 32'd8,        0, 0,  0};
    vt[7]  = '{32'h4030D093, 7,  1, 32'd1027,     0, 7,  0};
    vt[8]  = '{32'hFFFFFFFF, 0,  0, 32'h0,        1, 0,  1};
    vt[9]  = '{32'h0220C1B3, 0,  0, 32'h0,        1, 13, 0};
    vt[10] = '{32'h004100E7, 23, 1, 32'd4,        0, 23, 0};
    vt[11] = '{32'h00001097, 0,  4, 32'h1000,     0, 0,  0};
    vt[12] = '{32'hFFC12083, 0,  1, 32'hFFFFFFFC, 0, 0,  0};
    vt[13] = '{32'h00100073, 0,  1, 32'd1,        0, 0,  0};
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};

    // Reset state, held low with inputs active
    rst_n = 1'b0; in_valid = 1'b1; inst = 32'h402081B3; out_ready = 1'b1;
    flush = 1'b0; resume = 1'b0;
    #3;
    chk("rst_out_valid", o_vld, 0);
    chk("rst_stop", o_stop, 0);
    chk("rst_in_ready", o_rdy, 0);
    chk("rst_alu", o_alu, 0);
    chk("rst_imm", o_imm, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("first_in_ready", o_rdy, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("sub_valid", o_vld, 1);
    chk("sub_alu", o_alu, 1);
    chk("sub_sel", o_sel, 0);
    chk("sub_rs1", o_rs1, 1);
    chk("sub_rs2", o_rs2, 2);
    chk("sub_rd", o_rd, 3);
    tick();

    // Table of single instructions through an empty buffer
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; inst = vt[i].inst; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      #1;
      chk($sformatf("v%0d_valid", i), o_vld, 1);
      chk($sformatf("v%0d_alu", i), o_alu, vt[i].alu);
      chk($sformatf("v%0d_sel", i), o_sel, vt[i].sel);
      chk($sformatf("v%0d_imm", i), o_imm, vt[i].imm);
      chk($sformatf("v%0d_ill", i), o_ill, vt[i].ill);
      chk($sformatf("v%0d_rd", i), o_rd, vt[i].inst[11:7]);
      chk($sformatf("v%0d_m_alu", i), m_alu, vt[i].alu_m);
      chk($sformatf("v%0d_m_ill", i), m_ill, vt[i].ill_m);
      if (i == 13) tick();
      tick();
      if (i == 13) begin
        resume = 1'b1; tick(); resume = 1'b0;
      end
    end
    #1 chk("table_end_stop", o_stop, 0);

    // Backpressure: two fill the buffer, third waits, drain in order
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'h402081B3;
    #1 chk("bp_rdy0", o_rdy, 1);
    tick(); inst = 32'h040000EF;
    #1 chk("bp_rdy1", o_rdy, 1);
    tick(); inst = 32'h0420C063;
    #1 chk("bp_rdy_full", o_rdy, 0);
    tick(); out_ready = 1'b1;
    #1 chk("bp_no_passthru", o_rdy, 0);
    chk("bp_head0", o_alu, 1);
    tick();
    #1 chk("bp_rdy_after_pop", o_rdy, 1);
    chk("bp_head1", o_alu, 22);
    tick(); in_valid = 1'b0;
    #1 chk("bp_head2", o_alu, 18);
    tick();
    #1 chk("bp_empty", o_vld, 0);

    // ECALL halts intake, still drains; flush leaves halt; resume clears
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'h00000073;
    #1 chk("ecall_rdy", o_rdy, 1);
    tick(); inst = 32'h402081B3;
    #1 chk("ecall_stop", o_stop, 1);
    chk("ecall_in_ready", o_rdy, 0);
    chk("ecall_head_valid", o_vld, 1);
    chk("ecall_head_ill", o_ill, 0);
    out_ready = 1'b1;
    tick(); in_valid = 1'b0;
    #1 chk("ecall_popped", o_vld, 0);
    chk("ecall_stop_held", o_stop, 1);
    flush = 1'b1; tick(); flush = 1'b0;
    #1 chk("flush_keeps_stop", o_stop, 1);
    resume = 1'b1; tick(); resume = 1'b0;
    #1 chk("resume_stop", o_stop, 0);
    resume = 1'b1; in_valid = 1'b1; inst = 32'h00100073;
    #1 chk("ebreak_rdy", o_rdy, 1);
    tick(); resume = 1'b0; in_valid = 1'b0;
    #1 chk("ebreak_wins_resume", o_stop, 1);
    chk("ebreak_imm", o_imm, 1);
    tick(); resume = 1'b1; tick(); resume = 1'b0;

    // Flush with two buffered and a live input
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'h402081B3;
    tick(); inst = 32'h040000EF;
    tick(); inst = 32'h0420C063; flush = 1'b1; out_ready = 1'b1;
    #1 chk("flush_in_ready", o_rdy, 0);
    tick(); flush = 1'b0; in_valid = 1'b0;
    #1 chk("flush_empty", o_vld, 0);
    tick();
    #1 chk("flush_dropped", o_vld, 0);

    // Reset pulse mid-stream with a halt pending
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'h402081B3;
    tick(); inst = 32'h00000073;
    tick(); in_valid = 1'b0;
    #1 chk("pre_rst_stop", o_stop, 1);
    rst_n = 1'b0;
    #1 chk("mid_rst_valid", o_vld, 0);
    chk("mid_rst_stop", o_stop, 0);
    chk("mid_rst_rdy", o_rdy, 0);
    rst_n = 1'b1; in_valid = 1'b1; inst = 32'h040000EF;
    #1 chk("post_rst_rdy", o_rdy, 1);
    tick(); in_valid = 1'b0;
    #1 chk("post_rst_alu", o_alu, 22);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Randomized traffic against the queue model, both instances
    rst_n = 1'b0; #1 rst_n = 1'b1;
    mq.delete(); mhalt = 1'b0;
    tick();
    for (int c = 0; c < 3000; c++) begin
      bit exp_rdy, acc, pp;
      int r;
      logic [31:0] rw;
      ref_t e0, e1;
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 4);
      resume    = ($urandom_range(0, 99) < 15);
      r = $urandom_range(0, 9);
      rw = $urandom;
      if (r < 4) inst = vt[$urandom_range(0, 13)].inst;
      else if (r == 4) inst = rw[0] ? 32'h00000073 : 32'h00100073;
      else if (r == 5) inst = rw;
      else inst = {rw[31:7], opcs[$urandom_range(0, 9)]};
      #1;
      exp_rdy = (mq.size() < DEPTH) && !mhalt && !flush;
      chk("r_in_ready", o_rdy, exp_rdy);
      chk("r_m_in_ready", m_rdy, exp_rdy);
      chk("r_out_valid", o_vld, mq.size() > 0);
      chk("r_m_out_valid", m_vld, mq.size() > 0);
      chk("r_stop", o_stop, mhalt);
      chk("r_m_stop", m_stop, mhalt);
      if (mq.size() > 0) begin
        e0 = ref_dec(mq[0], 1'b0);
        e1 = ref_dec(mq[0], 1'b1);
        chk("r_alu", o_alu, e0.alu);
        chk("r_sel", o_sel, e0.sel);
        chk("r_imm", o_imm, e0.imm);
        chk("r_ill", o_ill, e0.ill);
        chk("r_rs1", o_rs1, mq[0][19:15]);
        chk("r_rs2", o_rs2, mq[0][24:20]);
        chk("r_rd", o_rd, mq[0][11:7]);
        chk("r_m_alu", m_alu, e1.alu);
        chk("r_m_ill", m_ill, e1.ill);
        chk("r_m_imm", m_imm, e1.imm);
      end
      acc = in_valid && exp_rdy;
      pp  = (mq.size() > 0) && out_ready;
      if (flush) mq.delete();
      else begin
        if (pp) void'(mq.pop_front());
        if (acc) mq.push_back(inst);
      end
      if (acc && is_halt(inst)) mhalt = 1'b1;
      else if (resume) mhalt = 1'b0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
